// File: rtl/sid_pkg.sv
// sid_pkg: shared types and constants for the SID combined-waveform table
// scheduler (table-output bundle, default table latency, sequencer states).
package sid_pkg;

    // Clock edges from driving the table address to valid table data.
    localparam int unsigned TBL_LAT_DEF = 2;

    // One combined-waveform lookup result.
    typedef struct packed {
        logic [7:0] st;
        logic [7:0] pt;
        logic [7:0] ps;
        logic [7:0] pst;
    } tbl_out_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Width of a voice index; never zero so a single-voice build still has a bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sid_tbl_lat_pipe.sv
// sid_tbl_lat_pipe: DEPTH-deep valid+index shift register that tracks which
// voice's table address is in flight, so results can be steered on arrival.
module sid_tbl_lat_pipe
    import sid_pkg::*;
#(
    parameter int unsigned DEPTH = TBL_LAT_DEF,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [IDX_W-1:0] push_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             inner_empty
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][IDX_W-1:0] idx;

    // Advance every stage one position per clock; stage 0 takes the new push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            idx <= '0;
        end else begin
            vld[0] <= push_vld;
            idx[0] <= push_vld ? push_idx : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    // True when nothing but the output stage holds an entry, i.e. the pipe
    // is empty after this edge if no new push arrives.
    always_comb begin
        inner_empty = 1'b1;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            if (vld[i]) inner_empty = 1'b0;
        end
    end

    assign out_vld = vld[DEPTH-1];
    assign out_idx = idx[DEPTH-1];

endmodule

// File: rtl/sid_table_sched.sv
// sid_table_sched: time-shares one combined-waveform table between the SID
// voices. Each ce_1m round snapshots requests and indices, issues one lookup
// per requesting voice in ascending order, and steers results back.
// Optional feature: define SID_TBL_SCHED_ZERO_EN to clear the result slices
// of non-requesting voices at each snapshot.
module sid_table_sched
    import sid_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ACC_W   = 12,
    parameter int unsigned TBL_LAT = TBL_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_1m,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*ACC_W-1:0] acc_ps,
    input  logic [NUM_REQ*ACC_W-1:0] acc_t,
    output logic [ACC_W-1:0]         tbl_acc_ps,
    output logic [ACC_W-1:0]         tbl_acc_t,
    input  logic [7:0]               tbl_st_in,
    input  logic [7:0]               tbl_pt_in,
    input  logic [7:0]               tbl_ps_in,
    input  logic [7:0]               tbl_pst_in,
    output logic [NUM_REQ*8-1:0]     st_out,
    output logic [NUM_REQ*8-1:0]     pt_out,
    output logic [NUM_REQ*8-1:0]     ps_out,
    output logic [NUM_REQ*8-1:0]     pst_out,
    output logic [NUM_REQ-1:0]       out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    sched_state_t               state;
    logic [NUM_REQ-1:0]         pend_mask;
    logic [NUM_REQ*ACC_W-1:0]   snap_ps;
    logic [NUM_REQ*ACC_W-1:0]   snap_t;
    logic                       restart;

    logic [IDX_W-1:0]           sel_idx;
    logic                       sel_found;
    logic                       last_issue;
    logic                       snap_take;
    logic                       push_vld;

    logic                       pipe_vld;
    logic [IDX_W-1:0]           pipe_idx;
    logic                       pipe_inner_empty;

    tbl_out_t                   tbl_cap;
    tbl_out_t [NUM_REQ-1:0]     res;

    // Lowest pending voice wins the next table slot.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pend_mask[i] && !sel_found) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign last_issue = (pend_mask & (pend_mask - NUM_REQ'(1))) == '0;
    assign push_vld   = (state == ST_ISSUE);

    // Snapshot edge: a fresh ce_1m in IDLE, or the end of a round with a
    // queued (or simultaneous) ce_1m so the next round starts without a gap.
    always_comb begin
        snap_take = 1'b0;
        case (state)
            ST_IDLE:  snap_take = ce_1m;
            ST_DRAIN: snap_take = pipe_inner_empty && (restart || ce_1m);
            default:  snap_take = 1'b0;
        endcase
    end

    // Round sequencer: snapshot, issue addresses, drain, plus overrun tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pend_mask  <= '0;
            snap_ps    <= '0;
            snap_t     <= '0;
            tbl_acc_ps <= '0;
            tbl_acc_t  <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            restart    <= 1'b0;
        end else begin
            if (state != ST_IDLE && ce_1m) begin
                overrun <= 1'b1;
                restart <= 1'b1;
            end
            if (snap_take) begin
                // Clearing restart here overrides the set above, so a ce_1m
                // landing on the final edge is consumed by this very snapshot.
                pend_mask <= req;
                snap_ps   <= acc_ps;
                snap_t    <= acc_t;
                restart   <= 1'b0;
                if (req != '0) begin
                    state <= ST_ISSUE;
                    busy  <= 1'b1;
                end else begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_ISSUE: begin
                        tbl_acc_ps <= snap_ps[sel_idx*ACC_W +: ACC_W];
                        tbl_acc_t  <= snap_t[sel_idx*ACC_W +: ACC_W];
                        pend_mask  <= pend_mask & (pend_mask - NUM_REQ'(1));
                        if (last_issue) state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (pipe_inner_empty) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sid_tbl_lat_pipe #(
        .DEPTH (TBL_LAT),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .clk         (clk),
        .reset       (reset),
        .push_vld    (push_vld),
        .push_idx    (sel_idx),
        .out_vld     (pipe_vld),
        .out_idx     (pipe_idx),
        .inner_empty (pipe_inner_empty)
    );

    assign tbl_cap = '{st: tbl_st_in, pt: tbl_pt_in, ps: tbl_ps_in, pst: tbl_pst_in};

    // Steer arriving table data into the owning voice's slice and pulse its valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res       <= '0;
            out_valid <= '0;
        end else begin
            out_valid <= '0;
`ifdef SID_TBL_SCHED_ZERO_EN
            if (snap_take) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!req[i]) res[i] <= '0;
                end
            end
`endif
            // A capture on the snapshot edge is newer data than the clear.
            if (pipe_vld) begin
                res[pipe_idx]       <= tbl_cap;
                out_valid[pipe_idx] <= 1'b1;
            end
        end
    end

    // Flatten per-voice results onto the packed output buses.
    always_comb begin
        st_out  = '0;
        pt_out  = '0;
        ps_out  = '0;
        pst_out = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            st_out[i*8 +: 8]  = res[i].st;
            pt_out[i*8 +: 8]  = res[i].pt;
            ps_out[i*8 +: 8]  = res[i].ps;
            pst_out[i*8 +: 8] = res[i].pst;
        end
    end

endmodule

// File: tb/tb_sid_table_sched.sv
// tb_sid_table_sched: six-voice build of the table scheduler with a stand-in
// table and a round-level reference model compared every cycle.
`timescale 1ns/1ps
module tb_sid_table_sched;

    localparam int unsigned N  = 6;
    localparam int unsigned AW = 12;
    localparam int unsigned L  = 2;

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic            ce_1m  = 1'b0;
    logic [N-1:0]    req    = '0;
    logic [N*AW-1:0] acc_ps = '0;
    logic [N*AW-1:0] acc_t  = '0;
    logic [AW-1:0]   tbl_acc_ps, tbl_acc_t;
    logic [7:0]      tbl_st_in, tbl_pt_in, tbl_ps_in, tbl_pst_in;
    logic [N*8-1:0]  st_out, pt_out, ps_out, pst_out;
    logic [N-1:0]    out_valid;
    logic            busy, overrun;

    int n_vec = 0;
    int n_bad = 0;
    int vq[$];

    always #5 clk = ~clk;

    sid_table_sched #(.NUM_REQ(N), .ACC_W(AW), .TBL_LAT(L)) dut (
        .clk        (clk),
        .reset      (rst),
        .ce_1m      (ce_1m),
        .req        (req),
        .acc_ps     (acc_ps),
        .acc_t      (acc_t),
        .tbl_acc_ps (tbl_acc_ps),
        .tbl_acc_t  (tbl_acc_t),
        .tbl_st_in  (tbl_st_in),
        .tbl_pt_in  (tbl_pt_in),
        .tbl_ps_in  (tbl_ps_in),
        .tbl_pst_in (tbl_pst_in),
        .st_out     (st_out),
        .pt_out     (pt_out),
        .ps_out     (ps_out),
        .pst_out    (pst_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    // Stand-in table: registered address, combinational decode (two-edge latency).
    logic [AW-1:0] t_ps_q = '0;
    logic [AW-1:0] t_t_q  = '0;
    always @(posedge clk) begin
        t_ps_q <= tbl_acc_ps;
        t_t_q  <= tbl_acc_t;
    end
    assign tbl_st_in  = t_ps_q[11:4];
    assign tbl_pt_in  = t_t_q[11:4];
    assign tbl_ps_in  = ~t_ps_q[11:4];
    assign tbl_pst_in = t_ps_q[7:0];

    function automatic logic [31:0] tbl_fn(input logic [11:0] ps, input logic [11:0] t);
        return {ps[11:4], t[11:4], ~ps[11:4], ps[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (round timeline) ----------------
    logic [23:0] addr_q [int];
    int          cap_v  [int];
    logic [31:0] cap_d  [int];
    logic [31:0] m_res  [N];
    logic [AW-1:0] m_addr_ps = '0, m_addr_t = '0;
    logic [N-1:0]  m_valid = '0;
    bit  m_busy = 0, m_overrun = 0, active = 0, restart_m = 0, take = 0;
    int  tcount = 0, round_end = 0, kk = 0;

    always @(posedge clk) begin
        if (rst) begin
            addr_q.delete(); cap_v.delete(); cap_d.delete();
            for (int v = 0; v < N; v++) m_res[v] = '0;
            m_addr_ps = '0; m_addr_t = '0; m_valid = '0;
            m_busy = 0; m_overrun = 0; active = 0; restart_m = 0;
        end else begin
            take = 0;
            if (ce_1m && active) begin
                m_overrun = 1;
                restart_m = 1;
            end
            if (active && tcount == round_end) begin
                active = 0;
                if (restart_m) begin
                    take = 1;
                    restart_m = 0;
                end
            end else if (!active && ce_1m) begin
                take = 1;
            end
            if (take) begin
                kk = 0;
                for (int v = 0; v < N; v++) begin
                    if (req[v]) begin
                        addr_q[tcount + 1 + kk] = {acc_t[v*AW +: AW], acc_ps[v*AW +: AW]};
                        cap_v[tcount + 1 + kk + L] = v;
                        cap_d[tcount + 1 + kk + L] = tbl_fn(acc_ps[v*AW +: AW], acc_t[v*AW +: AW]);
                        kk++;
                    end
`ifdef SID_TBL_SCHED_ZERO_EN
                    else m_res[v] = '0;
`endif
                end
                if (kk > 0) begin
                    active = 1;
                    round_end = tcount + kk + L;
                end
            end
            m_valid = '0;
            if (addr_q.exists(tcount)) begin
                {m_addr_t, m_addr_ps} = addr_q[tcount];
                addr_q.delete(tcount);
            end
            if (cap_v.exists(tcount)) begin
                m_res[cap_v[tcount]] = cap_d[tcount];
                m_valid[cap_v[tcount]] = 1'b1;
                cap_v.delete(tcount);
                cap_d.delete(tcount);
            end
            m_busy = active;
        end
        tcount++;
    end

    // ---------------- per-cycle compare ----------------
    logic [N*8-1:0] e_st, e_pt, e_ps, e_pst;
    always @(negedge clk) begin
        if (!rst) begin
            for (int v = 0; v < N; v++) begin
                e_st[v*8 +: 8]  = m_res[v][31:24];
                e_pt[v*8 +: 8]  = m_res[v][23:16];
                e_ps[v*8 +: 8]  = m_res[v][15:8];
                e_pst[v*8 +: 8] = m_res[v][7:0];
            end
            chk("tbl_acc_ps", 64'(tbl_acc_ps), 64'(m_addr_ps));
            chk("tbl_acc_t",  64'(tbl_acc_t),  64'(m_addr_t));
            chk("out_valid",  64'(out_valid),  64'(m_valid));
            chk("busy",       64'(busy),       64'(m_busy));
            chk("overrun",    64'(overrun),    64'(m_overrun));
            chk("st_out",     64'(st_out),     64'(e_st));
            chk("pt_out",     64'(pt_out),     64'(e_pt));
            chk("ps_out",     64'(ps_out),     64'(e_ps));
            chk("pst_out",    64'(pst_out),    64'(e_pst));
        end
    end

    // Bounded wait for the round(s) to finish, counting out_valid pulses.
    task automatic wait_idle(input string nm, output int pulses);
        int i = 0;
        pulses = 0;
        vq.delete();
        do begin
            @(negedge clk);
            pulses += $countones(out_valid);
            if (out_valid != '0) vq.push_back(int'(out_valid));
            i++;
        end while (busy && i < 200);
        chk({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_ovr"},  64'(overrun), 64'd0);
        chk({nm, "_vld"},  64'(out_valid), 64'd0);
        chk({nm, "_aps"},  64'(tbl_acc_ps), 64'd0);
        chk({nm, "_at"},   64'(tbl_acc_t), 64'd0);
        chk({nm, "_res"},  64'({st_out, pt_out} | {ps_out, pst_out}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (3) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;

        // 1: three voices, addresses 100/200/300
        @(negedge clk);
        acc_ps = '0;
        acc_ps[0*AW +: AW] = 12'h100;
        acc_ps[1*AW +: AW] = 12'h200;
        acc_ps[2*AW +: AW] = 12'h300;
        acc_t[0*AW +: AW]  = 12'hA10;
        acc_t[1*AW +: AW]  = 12'hB20;
        acc_t[2*AW +: AW]  = 12'hC30;
        req = 6'b000111; ce_1m = 1'b1;
        @(negedge clk); ce_1m = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        @(negedge clk); chk("t1_addr0", 64'(tbl_acc_ps), 64'h100);
        @(negedge clk); chk("t1_addr1", 64'(tbl_acc_ps), 64'h200);
        chk("t1_novld", 64'(out_valid), 64'd0);
        wait_idle("t1", p);
        chk("t1_pulses", 64'(p), 64'd3);
        chk("t1_st", 64'(st_out[23:0]), 64'h302010);

        // 2: single voice 1
        @(negedge clk);
        acc_ps[1*AW +: AW] = 12'h5A0;
        req = 6'b000010; ce_1m = 1'b1;
        @(negedge clk); ce_1m = 1'b0;
        wait_idle("t2", p);
        chk("t2_pulses", 64'(p), 64'd1);
`ifdef SID_TBL_SCHED_ZERO_EN
        chk("t2_st", 64'(st_out[23:0]), 64'h005A00);
`else
        chk("t2_st", 64'(st_out[23:0]), 64'h305A10);
`endif

        // 3: no requesters
        @(negedge clk);
        req = '0; ce_1m = 1'b1;
        @(negedge clk); ce_1m = 1'b0;
        chk("t3_busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("t3_addr", 64'(tbl_acc_ps), 64'h5A0);
        chk("t3_ovr", 64'(overrun), 64'd0);

        // 4: second ce_1m two edges into a round
        acc_ps[0*AW +: AW] = 12'h7E1;
        req = 6'b000111; ce_1m = 1'b1;
        @(negedge clk); ce_1m = 1'b0;
        @(negedge clk); ce_1m = 1'b1;
        @(negedge clk); ce_1m = 1'b0;
        wait_idle("t4", p);
        chk("t4_pulses", 64'(p), 64'd6);
        chk("t4_ovr", 64'(overrun), 64'd1);

        // 5: reset two edges into a round
        @(negedge clk);
        req = 6'b000111; ce_1m = 1'b1;
        @(negedge clk); ce_1m = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        #1 all_zero("t5");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_after", 64'(st_out), 64'd0);

        // 6: sparse request pattern 101001
        acc_ps[0*AW +: AW] = 12'h110;
        acc_ps[3*AW +: AW] = 12'h440;
        acc_ps[5*AW +: AW] = 12'h660;
        req = 6'b101001; ce_1m = 1'b1;
        @(negedge clk); ce_1m = 1'b0;
        wait_idle("t6", p);
        chk("t6_n", 64'(vq.size()), 64'd3);
        if (vq.size() == 3) begin
            chk("t6_ord0", 64'(vq[0]), 64'd1);
            chk("t6_ord1", 64'(vq[1]), 64'd8);
            chk("t6_ord2", 64'(vq[2]), 64'd32);
        end
        chk("t6_st", 64'(st_out), 64'h660044000011);

        // Randomized traffic, including overlapping ce_1m
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            req    = N'($urandom);
            acc_ps = (N*AW)'({$urandom(), $urandom(), $urandom()});
            acc_t  = (N*AW)'({$urandom(), $urandom(), $urandom()});
            ce_1m  = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk); ce_1m = 1'b0;
        wait_idle("final", p);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
